mem_resp_join: RTL and testbench

- Collects the even-bank and odd-bank cache read responses for one outstanding M-stage load and holds them until every bank the load needs has answered.
- Presents the joined pair to the output alignment stage directly downstream, together with the per-request metadata that stage needs: size, needP1, oddIsGreater and oneSize.
- Owns the ready/valid handshake between the two cache banks and the alignment/result path.
- One request in flight at a time.

---
 rtl/mem_pkg.sv | 33 +++
 rtl/mem_resp_join_if.sv | 62 ++++++
 rtl/mem_resp_join_resp_capture_reg.sv | 45 ++++
 rtl/mem_resp_join.sv | 198 +++++++++++++++++++
 tb/tb_mem_resp_join.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the memory response join block.
//   - FSM state encoding (IDLE/WAIT/FULL)
//   - load size encodings
//   - default widths for the bank line, physical and virtual address
//   - first_bank_bytes(): bytes a split access takes from its first bank
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    FULL = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SIZE_1B = 2'd0,
    SIZE_2B = 2'd1,
    SIZE_4B = 2'd2,
    SIZE_8B = 2'd3
  } size_t;

  localparam int LINE_W_DEF  = 128;
  localparam int PADDR_W_DEF = 15;
  localparam int VADDR_W_DEF = 32;

  // A split access starts at 'low' inside a 16-byte line and runs to the end
  // of it; the alignment stage only needs the low three bits of that count.
  function automatic logic [2:0] first_bank_bytes(input logic [3:0] low);
    logic [4:0] diff;
    diff = 5'd16 - {1'b0, low};
    return diff[2:0];
  endfunction

endpackage

// File: rtl/mem_resp_join_if.sv
// mem_resp_join_if: bundles the request, the two bank responses and the joined
// output toward the alignment stage.
//   master : issuing side (load pipe, banks, alignment stage consumer)
//   slave  : the mem_resp_join block
// Request   : req_valid/req_ready, req_size, req_needP1, req_oddIsGreater, req_vAddress
// Banks     : {E,O}_resp_valid, _miss, _data, _pAddress
// Output    : out_valid/out_ready, E/O_data, E/O_pAddress, out_vAddress,
//             out_size, out_needP1, out_oddIsGreater, oneSize, stall_out
interface mem_resp_join_if
  import mem_pkg::*;
#(
  parameter int LINE_W  = LINE_W_DEF,
  parameter int PADDR_W = PADDR_W_DEF,
  parameter int VADDR_W = VADDR_W_DEF
);
  logic               req_valid;
  logic               req_ready;
  logic [1:0]         req_size;
  logic               req_needP1;
  logic               req_oddIsGreater;
  logic [VADDR_W-1:0] req_vAddress;

  logic               E_resp_valid;
  logic               E_resp_miss;
  logic [LINE_W-1:0]  E_resp_data;
  logic [PADDR_W-1:0] E_resp_pAddress;
  logic               O_resp_valid;
  logic               O_resp_miss;
  logic [LINE_W-1:0]  O_resp_data;
  logic [PADDR_W-1:0] O_resp_pAddress;

  logic               out_valid;
  logic               out_ready;
  logic [LINE_W-1:0]  E_data;
  logic [LINE_W-1:0]  O_data;
  logic [PADDR_W-1:0] E_pAddress;
  logic [PADDR_W-1:0] O_pAddress;
  logic [VADDR_W-1:0] out_vAddress;
  logic [1:0]         out_size;
  logic               out_needP1;
  logic               out_oddIsGreater;
  logic [2:0]         oneSize;
  logic               stall_out;

  modport master (
    output req_valid, req_size, req_needP1, req_oddIsGreater, req_vAddress,
    output E_resp_valid, E_resp_miss, E_resp_data, E_resp_pAddress,
    output O_resp_valid, O_resp_miss, O_resp_data, O_resp_pAddress,
    output out_ready,
    input  req_ready, out_valid, E_data, O_data, E_pAddress, O_pAddress,
    input  out_vAddress, out_size, out_needP1, out_oddIsGreater, oneSize, stall_out
  );

  modport slave (
    input  req_valid, req_size, req_needP1, req_oddIsGreater, req_vAddress,
    input  E_resp_valid, E_resp_miss, E_resp_data, E_resp_pAddress,
    input  O_resp_valid, O_resp_miss, O_resp_data, O_resp_pAddress,
    input  out_ready,
    output req_ready, out_valid, E_data, O_data, E_pAddress, O_pAddress,
    output out_vAddress, out_size, out_needP1, out_oddIsGreater, oneSize, stall_out
  );
endinterface

// File: rtl/mem_resp_join_resp_capture_reg.sv
// resp_capture_reg: one bank's capture register.
//   clk, rst   : clock, synchronous active-high reset (clears data, address, got)
//   clr        : start of a new request; clears got, data/pAddress hold
//   load       : capture data_in/paddr_in and set got
//   data,paddr : held bank line and physical address
//   got        : this bank has answered the current request
module resp_capture_reg #(
  parameter int LINE_W  = 128,
  parameter int PADDR_W = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               load,
  input  logic [LINE_W-1:0]  data_in,
  input  logic [PADDR_W-1:0] paddr_in,
  output logic [LINE_W-1:0]  data,
  output logic [PADDR_W-1:0] paddr,
  output logic               got
);
  logic [LINE_W-1:0]  data_reg;
  logic [PADDR_W-1:0] paddr_reg;
  logic               got_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      data_reg  <= '0;
      paddr_reg <= '0;
      got_reg   <= 1'b0;
    end else begin
      if (clr) begin
        got_reg <= 1'b0;
      end
      if (load) begin
        data_reg  <= data_in;
        paddr_reg <= paddr_in;
        got_reg   <= 1'b1;
      end
    end
  end

  assign data  = data_reg;
  assign paddr = paddr_reg;
  assign got   = got_reg;
endmodule

// File: rtl/mem_resp_join.sv
// mem_resp_join: joins the even/odd cache bank responses of one outstanding
// M-stage load and hands the pair plus its metadata to the alignment stage.
//   clk, rst    : clock, synchronous active-high reset
//   bus (slave) : request handshake, E/O bank responses, joined output and
//                 stall_out (see mem_resp_join_if)
//   timeout_err : only with RESP_TIMEOUT_EN defined; sticky flag set once a
//                 request has waited 255+ cycles for its banks
// Optional feature macro: RESP_TIMEOUT_EN.
module mem_resp_join
  import mem_pkg::*;
#(
  parameter int LINE_W  = LINE_W_DEF,
  parameter int PADDR_W = PADDR_W_DEF,
  parameter int VADDR_W = VADDR_W_DEF
) (
  input  logic clk,
  input  logic rst,
  mem_resp_join_if.slave bus
`ifdef RESP_TIMEOUT_EN
  ,
  output logic timeout_err
`endif
);

  state_t             state_reg;
  logic [1:0]         need_reg;     // bit 0 = even bank, bit 1 = odd bank
  logic [1:0]         size_reg;
  logic               needp1_reg;
  logic               odd_greater_reg;
  logic [VADDR_W-1:0] vaddr_reg;
  logic [2:0]         one_size_reg;
  logic               out_valid_reg;
  logic               stall_reg;

  logic               req_ready;
  logic               accept;
  logic               in_wait;
  logic [1:0]         need_next;

  // Per-bank views indexed 0 = E, 1 = O so both banks share one generate loop.
  logic [1:0]         resp_valid;
  logic [1:0]         resp_miss;
  logic [LINE_W-1:0]  resp_data [2];
  logic [PADDR_W-1:0] resp_paddr [2];
  logic [LINE_W-1:0]  cap_data [2];
  logic [PADDR_W-1:0] cap_paddr [2];
  logic [1:0]         got;
  logic [1:0]         load;
  logic [1:0]         got_next;
  logic               done;
  logic [PADDR_W-1:0] first_paddr;
  logic [2:0]         one_size_next;

  assign resp_valid    = {bus.O_resp_valid, bus.E_resp_valid};
  assign resp_miss     = {bus.O_resp_miss, bus.E_resp_miss};
  assign resp_data[0]  = bus.E_resp_data;
  assign resp_data[1]  = bus.O_resp_data;
  assign resp_paddr[0] = bus.E_resp_pAddress;
  assign resp_paddr[1] = bus.O_resp_pAddress;

  // A FULL entry drained in the same cycle frees the slot for the next load.
  assign req_ready = (state_reg == IDLE) || ((state_reg == FULL) && bus.out_ready);
  assign accept    = bus.req_valid && req_ready;
  assign in_wait   = (state_reg == WAIT);

  assign need_next = bus.req_needP1       ? 2'b11 :
                     bus.req_oddIsGreater ? 2'b10 : 2'b01;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
      // Misses are dropped: the refill replays a clean response later.
      assign load[gi] = in_wait && resp_valid[gi] && !resp_miss[gi] &&
                        need_reg[gi] && !got[gi];

      resp_capture_reg #(
        .LINE_W  (LINE_W),
        .PADDR_W (PADDR_W)
      ) u_cap (
        .clk      (clk),
        .rst      (rst),
        .clr      (accept),
        .load     (load[gi]),
        .data_in  (resp_data[gi]),
        .paddr_in (resp_paddr[gi]),
        .data     (cap_data[gi]),
        .paddr    (cap_paddr[gi]),
        .got      (got[gi])
      );
    end
  endgenerate

  assign got_next = got | load;
  assign done     = in_wait && (got_next == need_reg);

  // The first bank's address may be arriving in the very cycle that completes
  // the join, so take it from the response bus in that case.
  always_comb begin
    first_paddr = '0;
    if (odd_greater_reg) begin
      first_paddr = load[1] ? resp_paddr[1] : cap_paddr[1];
    end else begin
      first_paddr = load[0] ? resp_paddr[0] : cap_paddr[0];
    end
    one_size_next = needp1_reg ? first_bank_bytes(first_paddr[3:0]) : 3'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      need_reg        <= 2'b00;
      size_reg        <= 2'd0;
      needp1_reg      <= 1'b0;
      odd_greater_reg <= 1'b0;
      vaddr_reg       <= '0;
      one_size_reg    <= 3'd0;
      out_valid_reg   <= 1'b0;
      stall_reg       <= 1'b0;
    end else begin
      if (accept) begin
        need_reg        <= need_next;
        size_reg        <= bus.req_size;
        needp1_reg      <= bus.req_needP1;
        odd_greater_reg <= bus.req_oddIsGreater;
        vaddr_reg       <= bus.req_vAddress;
      end
      case (state_reg)
        IDLE: begin
          if (accept) begin
            state_reg <= WAIT;
            stall_reg <= 1'b1;
          end
        end
        WAIT: begin
          if (done) begin
            state_reg     <= FULL;
            out_valid_reg <= 1'b1;
            stall_reg     <= 1'b0;
            one_size_reg  <= one_size_next;
          end
        end
        FULL: begin
          if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
            if (accept) begin
              state_reg <= WAIT;
              stall_reg <= 1'b1;
            end else begin
              state_reg <= IDLE;
              stall_reg <= 1'b0;
            end
          end
        end
        default: begin
          state_reg     <= IDLE;
          out_valid_reg <= 1'b0;
          stall_reg     <= 1'b0;
        end
      endcase
    end
  end

`ifdef RESP_TIMEOUT_EN
  logic [7:0] tmo_cnt_reg;
  logic       tmo_err_reg;

  // Diagnostic only: the FSM keeps waiting regardless of this flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_reg <= 8'd0;
      tmo_err_reg <= 1'b0;
    end else if (accept) begin
      tmo_cnt_reg <= 8'd0;
    end else if (in_wait) begin
      if (tmo_cnt_reg == 8'd255) begin
        tmo_err_reg <= 1'b1;
      end else begin
        tmo_cnt_reg <= tmo_cnt_reg + 8'd1;
      end
    end
  end

  assign timeout_err = tmo_err_reg;
`endif

  assign bus.req_ready        = req_ready;
  assign bus.out_valid        = out_valid_reg;
  assign bus.stall_out        = stall_reg;
  assign bus.E_data           = cap_data[0];
  assign bus.O_data           = cap_data[1];
  assign bus.E_pAddress       = cap_paddr[0];
  assign bus.O_pAddress       = cap_paddr[1];
  assign bus.out_vAddress     = vaddr_reg;
  assign bus.out_size         = size_reg;
  assign bus.out_needP1       = needp1_reg;
  assign bus.out_oddIsGreater = odd_greater_reg;
  assign bus.oneSize          = one_size_reg;

endmodule

// File: tb/tb_mem_resp_join.sv
// tb_mem_resp_join: scoreboard bench for mem_resp_join. Expected joined
// responses are queued when a request is issued and compared when the block
// presents out_valid. Honors RESP_TIMEOUT_EN when defined.
module tb_mem_resp_join;

  logic clk;
  logic rst;
`ifdef RESP_TIMEOUT_EN
  logic timeout_err;
`endif

  mem_resp_join_if #(.LINE_W(128), .PADDR_W(15), .VADDR_W(32)) bus ();

  mem_resp_join dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
`ifdef RESP_TIMEOUT_EN
    ,
    .timeout_err (timeout_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] e_data;
    logic [127:0] o_data;
    logic [14:0]  e_pa;
    logic [14:0]  o_pa;
    logic [31:0]  va;
    logic [1:0]   size;
    logic         np1;
    logic         oig;
    logic [2:0]   one;
  } exp_t;

  exp_t         sb[$];
  int           checks = 0;
  int           errors = 0;
  int           txn = 0;
  logic [127:0] e_hold = '0;
  logic [14:0]  e_pa_hold = '0;
  logic [127:0] o_hold = '0;
  logic [14:0]  o_pa_hold = '0;

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus.req_valid = 1'b0; bus.req_size = 2'd0; bus.req_needP1 = 1'b0;
    bus.req_oddIsGreater = 1'b0; bus.req_vAddress = '0;
    bus.E_resp_valid = 1'b0; bus.E_resp_miss = 1'b0; bus.E_resp_data = '0; bus.E_resp_pAddress = '0;
    bus.O_resp_valid = 1'b0; bus.O_resp_miss = 1'b0; bus.O_resp_data = '0; bus.O_resp_pAddress = '0;
    bus.out_ready = 1'b0;
  endtask

  // Queue the expected output; banks the load does not need keep old contents.
  task automatic push_exp(input logic [1:0] size, input logic np1, input logic oig,
                          input logic [31:0] va, input logic [127:0] ed, input logic [14:0] ep,
                          input logic [127:0] od, input logic [14:0] op);
    exp_t e;
    bit need_e, need_o;
    int first_low;
    need_e = np1 || !oig;
    need_o = np1 || oig;
    if (need_e) begin e_hold = ed; e_pa_hold = ep; end
    if (need_o) begin o_hold = od; o_pa_hold = op; end
    e.e_data = e_hold; e.e_pa = e_pa_hold;
    e.o_data = o_hold; e.o_pa = o_pa_hold;
    e.va = va; e.size = size; e.np1 = np1; e.oig = oig;
    first_low = oig ? int'(op[3:0]) : int'(ep[3:0]);
    e.one = np1 ? 3'((16 - first_low) % 8) : 3'd0;
    sb.push_back(e);
  endtask

  // Issue a request from the current (ready) state; returns at the negedge
  // after the accepting edge.
  task automatic send_req(input logic [1:0] size, input logic np1, input logic oig,
                          input logic [31:0] va);
    bus.req_valid = 1'b1; bus.req_size = size; bus.req_needP1 = np1;
    bus.req_oddIsGreater = oig; bus.req_vAddress = va;
    #1;
    check_val("req_ready_accept", bus.req_ready, 1'b1);
    tick();
    bus.req_valid = 1'b0;
  endtask

  task automatic set_e(input logic valid, input logic miss, input logic [127:0] d, input logic [14:0] pa);
    bus.E_resp_valid = valid; bus.E_resp_miss = miss; bus.E_resp_data = d; bus.E_resp_pAddress = pa;
  endtask

  task automatic set_o(input logic valid, input logic miss, input logic [127:0] d, input logic [14:0] pa);
    bus.O_resp_valid = valid; bus.O_resp_miss = miss; bus.O_resp_data = d; bus.O_resp_pAddress = pa;
  endtask

  task automatic drop_resp();
    bus.E_resp_valid = 1'b0; bus.E_resp_miss = 1'b0;
    bus.O_resp_valid = 1'b0; bus.O_resp_miss = 1'b0;
  endtask

  task automatic expect_out(input string tag);
    exp_t e;
    check_val({tag, "_out_valid"}, bus.out_valid, 1'b1);
    check_val({tag, "_sb_nonempty"}, sb.size() != 0, 1'b1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    txn++;
    $display("txn %0d %s: size=%0d needP1=%0b oddIsGreater=%0b oneSize=%0d E_pA=%0h O_pA=%0h",
             txn, tag, bus.out_size, bus.out_needP1, bus.out_oddIsGreater, bus.oneSize,
             bus.E_pAddress, bus.O_pAddress);
    check_val({tag, "_E_data"}, bus.E_data, e.e_data);
    check_val({tag, "_O_data"}, bus.O_data, e.o_data);
    check_val({tag, "_E_pAddress"}, bus.E_pAddress, e.e_pa);
    check_val({tag, "_O_pAddress"}, bus.O_pAddress, e.o_pa);
    check_val({tag, "_vAddress"}, bus.out_vAddress, e.va);
    check_val({tag, "_size"}, bus.out_size, e.size);
    check_val({tag, "_needP1"}, bus.out_needP1, e.np1);
    check_val({tag, "_oddIsGreater"}, bus.out_oddIsGreater, e.oig);
    check_val({tag, "_oneSize"}, bus.oneSize, e.one);
    check_val({tag, "_stall_full"}, bus.stall_out, 1'b0);
  endtask

  task automatic consume(input string tag);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check_val({tag, "_drained_valid"}, bus.out_valid, 1'b0);
    check_val({tag, "_drained_ready"}, bus.req_ready, 1'b1);
    check_val({tag, "_drained_stall"}, bus.stall_out, 1'b0);
  endtask

  initial begin
    logic [127:0] held_o;
    logic [127:0] ed, od;
    logic [14:0]  ep, op;
    logic [31:0]  va;
    logic         np1, oig;
    logic [1:0]   sz;
    int           d;

    clear_inputs();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;

    // Reset state
    check_val("rst_req_ready", bus.req_ready, 1'b1);
    check_val("rst_out_valid", bus.out_valid, 1'b0);
    check_val("rst_stall", bus.stall_out, 1'b0);
    check_val("rst_oneSize", bus.oneSize, 3'd0);
    check_val("rst_E_data", bus.E_data, 128'd0);
`ifdef RESP_TIMEOUT_EN
    check_val("rst_timeout_err", timeout_err, 1'b0);
`endif

    // Aligned 4B load on the even bank; odd response must be ignored
    push_exp(2'd2, 1'b0, 1'b0, 32'h1000_00A4, 128'h0123_4567_89AB_CDEF_0000_0000_DEAD_BEEF,
             15'h0A4, 128'd0, 15'd0);
    send_req(2'd2, 1'b0, 1'b0, 32'h1000_00A4);
    check_val("a4_wait_stall", bus.stall_out, 1'b1);
    check_val("a4_wait_ready", bus.req_ready, 1'b0);
    check_val("a4_wait_valid", bus.out_valid, 1'b0);
    set_o(1'b1, 1'b0, 128'h1111, 15'h0B0);
    tick(); drop_resp();
    check_val("a4_odd_ignored", bus.out_valid, 1'b0);
    set_e(1'b1, 1'b0, 128'h0123_4567_89AB_CDEF_0000_0000_DEAD_BEEF, 15'h0A4);
    tick(); drop_resp();
    expect_out("aligned4B");
    consume("aligned4B");

    // Split 8B load: odd first at T, even at T+3, out_valid exactly at T+4
    push_exp(2'd3, 1'b1, 1'b1, 32'h2000_001D, 128'hE0E0, 15'h020, 128'h0D0D, 15'h01D);
    send_req(2'd3, 1'b1, 1'b1, 32'h2000_001D);
    set_o(1'b1, 1'b0, 128'h0D0D, 15'h01D);
    tick(); drop_resp();
    check_val("split_T1", bus.out_valid, 1'b0);
    tick();
    check_val("split_T2", bus.out_valid, 1'b0);
    tick();
    check_val("split_T3", bus.out_valid, 1'b0);
    set_e(1'b1, 1'b0, 128'hE0E0, 15'h020);
    tick(); drop_resp();
    expect_out("split8B");
    consume("split8B");

    // Miss then refill on the even bank
    push_exp(2'd0, 1'b0, 1'b0, 32'h3000_0003, 128'h55, 15'h103, 128'd0, 15'd0);
    send_req(2'd0, 1'b0, 1'b0, 32'h3000_0003);
    set_e(1'b1, 1'b1, 128'hAA, 15'h1FF);
    tick(); drop_resp();
    for (int i = 1; i < 10; i++) begin
      check_val("miss_no_valid", bus.out_valid, 1'b0);
      tick();
    end
    check_val("miss_T10", bus.out_valid, 1'b0);
    set_e(1'b1, 1'b0, 128'h55, 15'h103);
    tick(); drop_resp();
    expect_out("refill");
    consume("refill");

    // Both banks answer in the same cycle
    push_exp(2'd3, 1'b1, 1'b0, 32'h4000_000A, 128'hCAFE, 15'h00A, 128'hF00D, 15'h010);
    send_req(2'd3, 1'b1, 1'b0, 32'h4000_000A);
    set_e(1'b1, 1'b0, 128'hCAFE, 15'h00A);
    set_o(1'b1, 1'b0, 128'hF00D, 15'h010);
    tick(); drop_resp();
    expect_out("same_cycle");
    consume("same_cycle");

    // Backpressure hold, then back-to-back accept
    push_exp(2'd1, 1'b0, 1'b1, 32'h5000_0040, 128'd0, 15'd0, 128'hB0B0_B0B0, 15'h040);
    send_req(2'd1, 1'b0, 1'b1, 32'h5000_0040);
    set_o(1'b1, 1'b0, 128'hB0B0_B0B0, 15'h040);
    tick(); drop_resp();
    expect_out("hold");
    held_o = bus.O_data;
    for (int i = 0; i < 4; i++) begin
      set_e(1'b1, 1'b0, {4{$urandom}}, 15'($urandom));
      set_o(1'b1, 1'b0, {4{$urandom}}, 15'($urandom));
      tick();
      check_val("hold_valid", bus.out_valid, 1'b1);
      check_val("hold_stall", bus.stall_out, 1'b0);
      check_val("hold_O_data", bus.O_data, 128'hB0B0_B0B0);
      check_val("hold_O_pAddress", bus.O_pAddress, 15'h040);
      check_val("hold_E_data", bus.E_data, e_hold);
      check_val("hold_size", bus.out_size, 2'd1);
    end
    drop_resp();
    push_exp(2'd2, 1'b0, 1'b0, 32'h6000_0064, 128'h7777, 15'h064, 128'd0, 15'd0);
    bus.out_ready = 1'b1;
    send_req(2'd2, 1'b0, 1'b0, 32'h6000_0064);
    bus.out_ready = 1'b0;
    check_val("b2b_valid_drop", bus.out_valid, 1'b0);
    check_val("b2b_stall", bus.stall_out, 1'b1);
    check_val("b2b_ready", bus.req_ready, 1'b0);
    set_e(1'b1, 1'b0, 128'h7777, 15'h064);
    tick(); drop_resp();
    expect_out("b2b");
    consume("b2b");

    // Randomised joins with random response spacing
    for (int t = 0; t < 6; t++) begin
      np1 = 1'($urandom_range(0, 1));
      oig = 1'($urandom_range(0, 1));
      sz  = 2'($urandom_range(0, 3));
      va  = $urandom;
      ed  = {$urandom, $urandom, $urandom, $urandom};
      od  = {$urandom, $urandom, $urandom, $urandom};
      ep  = 15'($urandom);
      op  = 15'($urandom);
      push_exp(sz, np1, oig, va, ed, ep, od, op);
      send_req(sz, np1, oig, va);
      if (np1) begin
        d = $urandom_range(0, 2);
        set_e(1'b1, 1'b0, ed, ep);
        if (d == 0) set_o(1'b1, 1'b0, od, op);
        tick(); drop_resp();
        if (d != 0) begin
          repeat (d - 1) tick();
          check_val("rand_partial", bus.out_valid, 1'b0);
          set_o(1'b1, 1'b0, od, op);
          tick(); drop_resp();
        end
      end else begin
        if (oig) set_o(1'b1, 1'b0, od, op);
        else     set_e(1'b1, 1'b0, ed, ep);
        tick(); drop_resp();
      end
      expect_out("random");
      consume("random");
    end

`ifdef RESP_TIMEOUT_EN
    // No response for well over 256 cycles: sticky error, FSM keeps waiting
    push_exp(2'd2, 1'b0, 1'b0, 32'h7000_0010, 128'h9999, 15'h010, 128'd0, 15'd0);
    send_req(2'd2, 1'b0, 1'b0, 32'h7000_0010);
    check_val("tmo_early", timeout_err, 1'b0);
    repeat (300) tick();
    check_val("tmo_err", timeout_err, 1'b1);
    check_val("tmo_still_wait", bus.stall_out, 1'b1);
    check_val("tmo_no_valid", bus.out_valid, 1'b0);
    set_e(1'b1, 1'b0, 128'h9999, 15'h010);
    tick(); drop_resp();
    expect_out("after_timeout");
    consume("after_timeout");
    check_val("tmo_sticky", timeout_err, 1'b1);
`endif

    // Reset while waiting discards the request; later responses are ignored
    send_req(2'd2, 1'b0, 1'b0, 32'h8000_0000);
    check_val("rstw_in_wait", bus.stall_out, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    e_hold = '0; e_pa_hold = '0; o_hold = '0; o_pa_hold = '0;
    check_val("rstw_ready", bus.req_ready, 1'b1);
    check_val("rstw_stall", bus.stall_out, 1'b0);
    check_val("rstw_valid", bus.out_valid, 1'b0);
    check_val("rstw_E_data", bus.E_data, 128'd0);
    set_e(1'b1, 1'b0, 128'h4444, 15'h044);
    tick(); drop_resp();
    check_val("rstw_resp_ignored_valid", bus.out_valid, 1'b0);
    check_val("rstw_resp_ignored_data", bus.E_data, 128'd0);
`ifdef RESP_TIMEOUT_EN
    check_val("rstw_timeout_cleared", timeout_err, 1'b0);
`endif

    check_val("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
